uart_rx: RTL and testbench

//   UART receiver consuming the 16x oversampling tick from baudrate_generator.

---
 rtl/uart_rx_if.sv | 11 +
 rtl/uart_rx.sv | 92 +++++++++
 tb/tb_uart_rx.sv | 120 ++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// uart_rx_if: receiver bus; master drives rx and s_tick, slave (the receiver) returns dout, rx_done_tick, frame_err, busy
interface uart_rx_if #(parameter int DBIT = 8);
  logic rx;
  logic s_tick;
  logic [DBIT-1:0] dout;
  logic rx_done_tick;
  logic frame_err;
  logic busy;
  modport master (output rx, s_tick, input dout, rx_done_tick, frame_err, busy);
  modport slave (input rx, s_tick, output dout, rx_done_tick, frame_err, busy);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver; ports clk, reset (sync, active-high), bus (rx, s_tick in; dout, rx_done_tick, frame_err, busy out)
module uart_rx #(
  parameter int DBIT = 8,
  parameter int SB_TICK = 16,
  parameter int OVS = 16
) (
  input logic clk,
  input logic reset,
  uart_rx_if.slave bus
);
  localparam int SW = $clog2(OVS > SB_TICK ? OVS : SB_TICK);
  localparam int NW = $clog2(DBIT);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic rx_m, rx_s;
  logic [SW-1:0] s, s_n;
  logic [NW-1:0] n, n_n;
  logic [DBIT-1:0] shift, shift_n, dout, dout_n;
  logic done, done_n, ferr, ferr_n;
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      state <= IDLE;
      s <= '0;
      n <= '0;
      shift <= '0;
      dout <= '0;
      ferr <= 1'b0;
      done <= 1'b0;
    end else begin
      rx_m <= bus.rx;
      rx_s <= rx_m;
      state <= state_n;
      s <= s_n;
      n <= n_n;
      shift <= shift_n;
      dout <= dout_n;
      ferr <= ferr_n;
      done <= done_n;
    end
  end
  always_comb begin
    state_n = state;
    s_n = s;
    n_n = n;
    shift_n = shift;
    dout_n = dout;
    ferr_n = ferr;
    done_n = 1'b0;
    case (state)
      IDLE:
        if (!rx_s) begin
          state_n = START;
          s_n = '0;
        end
      START:
        if (bus.s_tick) begin
          if (s == SW'(OVS / 2 - 1)) begin
            state_n = rx_s ? IDLE : DATA;
            s_n = '0;
            n_n = '0;
          end else s_n = s + 1'b1;
        end
      DATA:
        if (bus.s_tick) begin
          if (s == SW'(OVS - 1)) begin
            s_n = '0;
            shift_n = {rx_s, shift[DBIT-1:1]};
            state_n = (n == NW'(DBIT - 1)) ? STOP : DATA;
            n_n = (n == NW'(DBIT - 1)) ? n : n + 1'b1;
          end else s_n = s + 1'b1;
        end
      STOP:
        if (bus.s_tick) begin
          if (s == SW'(SB_TICK - 1)) begin
            state_n = IDLE;
            dout_n = shift;
            ferr_n = ~rx_s;
            done_n = 1'b1;
          end else s_n = s + 1'b1;
        end
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    bus.busy = (state != IDLE);
    bus.dout = dout;
    bus.frame_err = ferr;
    bus.rx_done_tick = done;
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and random frames against a queue-based frame model of uart_rx
module tb_uart_rx;
  localparam int BIT_CLK = 64;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_checks = 0;
  int n_fail = 0;
  int tc = 0;
  logic [8:0] exp_q[$];
  logic [8:0] obs_q[$];
  logic [7:0] m_dout = 8'h00;
  logic m_ferr = 1'b0;
  uart_rx_if #(.DBIT(8)) bus ();
  uart_rx #(.DBIT(8), .SB_TICK(16), .OVS(16)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    bus.s_tick = 1'b0;
    forever begin
      @(negedge clk);
      tc = (tc == 3) ? 0 : tc + 1;
      bus.s_tick = (tc == 0);
    end
  end
  always @(negedge clk) if (bus.rx_done_tick) obs_q.push_back({bus.frame_err, bus.dout});
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic v, input int ncl);
    bus.rx = v;
    repeat (ncl) @(negedge clk);
  endtask
  task automatic send_frame(input logic [7:0] b, input bit ok);
    drive(1'b0, BIT_CLK);
    for (int i = 0; i < 8; i++) drive(b[i], BIT_CLK);
    if (ok) drive(1'b1, BIT_CLK);
    else begin
      drive(1'b0, BIT_CLK * 3 / 4);
      drive(1'b1, BIT_CLK / 4);
    end
    exp_q.push_back({~ok, b});
    m_dout = b;
    m_ferr = ~ok;
  endtask
  task automatic check_frames(input string tag);
    logic [8:0] e, o;
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      chk({tag, "_frame"}, o, e);
    end
    exp_q.delete();
    obs_q.delete();
    chk({tag, "_dout"}, bus.dout, m_dout);
    chk({tag, "_ferr"}, bus.frame_err, m_ferr);
    chk({tag, "_busy"}, bus.busy, 1'b0);
  endtask
  initial begin
    logic [7:0] b;
    bit ok;
    bus.rx = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_dout", bus.dout, 8'h00);
      chk("rst_done", bus.rx_done_tick, 1'b0);
    end
    bus.rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 20);
    send_frame(8'hA5, 1'b1);
    drive(1'b1, 40);
    check_frames("a5");
    send_frame(8'h3C, 1'b0);
    drive(1'b1, 80);
    check_frames("3c_ferr");
    drive(1'b0, 16);
    drive(1'b1, 200);
    check_frames("glitch");
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h55, 1'b1);
    drive(1'b1, 80);
    check_frames("b2b");
    b = 8'h81;
    drive(1'b0, BIT_CLK);
    for (int i = 0; i < 3; i++) drive(b[i], BIT_CLK);
    drive(b[3], BIT_CLK / 2);
    reset = 1'b1;
    bus.rx = 1'b1;
    repeat (10) @(negedge clk);
    chk("midrst_busy", bus.busy, 1'b0);
    chk("midrst_dout", bus.dout, 8'h00);
    reset = 1'b0;
    m_dout = 8'h00;
    m_ferr = 1'b0;
    drive(1'b1, 700);
    check_frames("midrst_idle");
    send_frame(8'h42, 1'b1);
    drive(1'b1, 80);
    check_frames("after_rst");
    for (int k = 0; k < 12; k++) begin
      b = 8'($urandom);
      ok = ($urandom_range(0, 3) != 0);
      send_frame(b, ok);
      drive(1'b1, $urandom_range(0, 100) + (ok ? 0 : BIT_CLK));
      if (k % 3 == 2) begin
        drive(1'b1, 80);
        check_frames("rand");
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
